// File: rtl/capture_seq_ctrl.sv
// rtl/capture_seq_ctrl.sv - capture FIFO sequencer between decimated ADC stream and PIC readout
//
// Sequence: IDLE -> FILL (pre-trigger fill) -> ARMED (rolling pre-trigger window)
//           -> POST (post-trigger fill) -> READY (PIC readout) -> re-arm or IDLE.
// Optional feature macro: CAPTURE_HOLDOFF_EN (adds cfg_holdoff trigger holdoff after ARMED entry).
//
// Ports:
//   clk, rst_n          decimated sample clock, asynchronous active-low reset
//   sample_valid        new decimated sample this cycle
//   trig_in, force_trig trigger sources (pulses)
//   arm, abort          host control pulses
//   cfg_mode            00 normal, 01 single, 10 auto, 11 normal
//   cfg_pre             pre-trigger sample count, latched on FILL entry
//   cfg_holdoff         (CAPTURE_HOLDOFF_EN only) samples to ignore triggers after ARMED entry
//   rd_strobe           synchronised PIC read pulse
//   fifo_wren/rden/clr  FIFO strobes
//   buf_ready           buffer complete, PIC may read
//   trig_seen           one-cycle pulse on accepted trigger
//   state, occupancy    current state encoding and FIFO fill level
module capture_seq_ctrl #(
    parameter int DEPTH   = 8192,
    parameter int CNT_W   = 14,
    parameter int AUTO_TO = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic             trig_in,
    input  logic             force_trig,
    input  logic             arm,
    input  logic             abort,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_pre,
`ifdef CAPTURE_HOLDOFF_EN
    input  logic [CNT_W-1:0] cfg_holdoff,
`endif
    input  logic             rd_strobe,
    output logic             fifo_wren,
    output logic             fifo_rden,
    output logic             fifo_clr,
    output logic             buf_ready,
    output logic             trig_seen,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] occupancy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READY = 3'd4
    } state_t;

    localparam int                AUTO_W    = $clog2(AUTO_TO + 1);
    localparam logic [CNT_W-1:0]  PRE_MAX   = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TO - 1);
    localparam logic [AUTO_W-1:0] AUTO_ONE  = AUTO_W'(1);

    state_t            cur;
    logic [CNT_W-1:0]  pre_l;
    logic [CNT_W-1:0]  post_cnt;
    logic [AUTO_W-1:0] auto_cnt;

    logic [CNT_W-1:0]  pre_clamped;
    logic              auto_mode;
    logic              single_mode;
    logic              auto_hit;
    logic              trig_ok;
    logic              trig_req;
    logic              rd_ok;
    logic              ready_done;

    assign state       = cur;
    assign pre_clamped = (cfg_pre > PRE_MAX) ? PRE_MAX : cfg_pre;
    assign auto_mode   = (cfg_mode == 2'b10);
    assign single_mode = (cfg_mode == 2'b01);

    // The auto timeout fires on the sample that brings the idle count to AUTO_TO.
    assign auto_hit    = auto_mode && sample_valid && (auto_cnt == AUTO_LAST);

`ifdef CAPTURE_HOLDOFF_EN
    // Samples written since ARMED entry; saturates so a large holdoff cannot wrap.
    logic [CNT_W-1:0] hold_cnt;
    assign trig_ok = (hold_cnt >= cfg_holdoff);
`else
    assign trig_ok = 1'b1;
`endif

    assign trig_req   = (trig_in | force_trig | auto_hit) & trig_ok;

    // Reads are only granted while data is held, so the FIFO cannot underflow.
    assign rd_ok      = rd_strobe && (occupancy != '0);
    assign ready_done = (occupancy == '0) || (rd_ok && (occupancy == CNT_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= S_IDLE;
            fifo_wren <= 1'b0;
            fifo_rden <= 1'b0;
            fifo_clr  <= 1'b0;
            buf_ready <= 1'b0;
            trig_seen <= 1'b0;
            occupancy <= '0;
            pre_l     <= '0;
            post_cnt  <= '0;
            auto_cnt  <= '0;
`ifdef CAPTURE_HOLDOFF_EN
            hold_cnt  <= '0;
`endif
        end else begin
            fifo_wren <= 1'b0;
            fifo_rden <= 1'b0;
            fifo_clr  <= 1'b0;
            trig_seen <= 1'b0;

            if (abort) begin
                cur       <= S_IDLE;
                fifo_clr  <= 1'b1;
                buf_ready <= 1'b0;
                occupancy <= '0;
                post_cnt  <= '0;
                auto_cnt  <= '0;
`ifdef CAPTURE_HOLDOFF_EN
                hold_cnt  <= '0;
`endif
            end else begin
                case (cur)
                    S_IDLE: begin
                        if (arm) begin
                            fifo_clr  <= 1'b1;
                            occupancy <= '0;
                            pre_l     <= pre_clamped;
                            cur       <= S_FILL;
                        end
                    end

                    S_FILL: begin
                        // Checked before writing so the window never overshoots pre_l.
                        if (occupancy == pre_l) begin
                            cur <= S_ARMED;
                        end else if (sample_valid) begin
                            fifo_wren <= 1'b1;
                            occupancy <= occupancy + CNT_ONE;
                        end
                    end

                    S_ARMED: begin
                        // Write newest, discard oldest: occupancy holds at pre_l.
                        fifo_wren <= sample_valid;
                        fifo_rden <= sample_valid;
                        if (auto_mode && sample_valid) begin
                            auto_cnt <= auto_hit ? '0 : auto_cnt + AUTO_ONE;
                        end
`ifdef CAPTURE_HOLDOFF_EN
                        if (sample_valid && (hold_cnt != '1)) begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end
`endif
                        if (trig_req) begin
                            trig_seen <= 1'b1;
                            post_cnt  <= DEPTH_C - pre_l;
                            auto_cnt  <= '0;
`ifdef CAPTURE_HOLDOFF_EN
                            hold_cnt  <= '0;
`endif
                            cur       <= S_POST;
                        end
                    end

                    S_POST: begin
                        // post_cnt >= 1 on entry since pre_l <= DEPTH-1.
                        if (sample_valid) begin
                            fifo_wren <= 1'b1;
                            occupancy <= occupancy + CNT_ONE;
                            post_cnt  <= post_cnt - CNT_ONE;
                            if (post_cnt == CNT_ONE) begin
                                buf_ready <= 1'b1;
                                cur       <= S_READY;
                            end
                        end
                    end

                    S_READY: begin
                        if (rd_ok) begin
                            fifo_rden <= 1'b1;
                            occupancy <= occupancy - CNT_ONE;
                        end
                        if (ready_done) begin
                            buf_ready <= 1'b0;
                            if (single_mode) begin
                                cur <= S_IDLE;
                            end else begin
                                fifo_clr <= 1'b1;
                                pre_l    <= pre_clamped;
                                cur      <= S_FILL;
                            end
                        end
                    end

                    default: cur <= S_IDLE;
                endcase
            end
        end
    end

endmodule
